// File: rtl/mul_seq_64.sv
// Sequential shift-add multiplier, W x W -> 2W, early exit at the multiplier's top set bit.
// Optional macro MUL_SIGNED_EN: two's-complement operands (magnitude multiply plus sign fix-up).
module mul_seq_64 #(
  parameter int W = 64
) (
  input  logic           clk_i,
  input  logic           reset,
  input  logic           start_i,
  input  logic [W-1:0]   X_i,
  input  logic [W-1:0]   Y_i,
  output logic           busy_o,
  output logic           rdy_o,
  output logic [2*W-1:0] P_o
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [2*W-1:0]  mcand;
  logic [W-1:0]    mplier;
  logic [2*W-1:0]  acc;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    x_mag;
  logic [W-1:0]    y_mag;

  // Index of the highest set bit; this sets the number of RUN cycles minus one.
  function automatic logic [CW-1:0] msb_idx(input logic [W-1:0] v);
    msb_idx = '0;
    for (int i = 0; i < W; i++)
      if (v[i]) msb_idx = CW'(i);
  endfunction

`ifdef MUL_SIGNED_EN
  logic neg;

  // Negating the most negative value wraps to 2^(W-1), which is the correct unsigned magnitude.
  assign x_mag = X_i[W-1] ? -X_i : X_i;
  assign y_mag = Y_i[W-1] ? -Y_i : Y_i;
  assign P_o   = neg ? -acc : acc;

  always_ff @(posedge clk_i) begin
    if (!reset)
      neg <= 1'b0;
    else if (state == IDLE && start_i)
      neg <= X_i[W-1] ^ Y_i[W-1];
  end
`else
  assign x_mag = X_i;
  assign y_mag = Y_i;
  assign P_o   = acc;
`endif

  assign busy_o = (state == RUN);
  assign rdy_o  = (state == DONE);

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values;
  // reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge clk_i) begin
    if (!reset) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            mcand  <= {{W{1'b0}}, x_mag};
            mplier <= y_mag;
            acc    <= '0;
            cnt    <= msb_idx(y_mag);
            state  <= (X_i == '0 || Y_i == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (!start_i) begin
            // Abort: discard the partial product without accumulating on this edge.
            state <= IDLE;
            acc   <= '0;
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt == '0) state <= DONE;
            else           cnt   <= cnt - CW'(1);
          end
        end
        DONE: begin
          if (!start_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_64.sv
// Self-checking bench for mul_seq_64: directed cases from the test plan plus random operands
// against an arithmetic reference model (honours MUL_SIGNED_EN if defined).
module tb_mul_seq_64;

  logic          clk_i = 1'b0;
  logic          reset;
  logic          start_i;
  logic [63:0]   X_i;
  logic [63:0]   Y_i;
  logic          busy_o;
  logic          rdy_o;
  logic [127:0]  P_o;

  int tests_run = 0;
  int tests_failed = 0;

  mul_seq_64 #(.W(64)) dut (
    .clk_i  (clk_i),
    .reset  (reset),
    .start_i(start_i),
    .X_i    (X_i),
    .Y_i    (Y_i),
    .busy_o (busy_o),
    .rdy_o  (rdy_o),
    .P_o    (P_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [127:0] model_prod(input logic [63:0] x, input logic [63:0] y);
    logic signed [127:0] sx;
    logic signed [127:0] sy;
`ifdef MUL_SIGNED_EN
    sx = 128'($signed(x));
    sy = 128'($signed(y));
`else
    sx = {64'b0, x};
    sy = {64'b0, y};
`endif
    return sx * sy;
  endfunction

  // Cycles spent in RUN: position of the top set bit of |y| plus one, zero for a zero operand.
  function automatic int model_lat(input logic [63:0] x, input logic [63:0] y);
    logic [63:0] mag;
    int k;
    if (x == 64'd0 || y == 64'd0) return 0;
    mag = y;
`ifdef MUL_SIGNED_EN
    if (y[63]) mag = -y;
`endif
    k = 0;
    while (mag > 64'd1) begin
      mag = mag >> 1;
      k++;
    end
    return k + 1;
  endfunction

  // Full handshake: start, count RUN cycles, check product, hold start, release.
  task automatic run_op(input string tag, input logic [63:0] x, input logic [63:0] y, input int hold);
    logic [127:0] exp_p;
    int lat;
    int n;
    exp_p = model_prod(x, y);
    lat = model_lat(x, y);
    start_i = 1'b1;
    X_i = x;
    Y_i = y;
    step();
    X_i = {$urandom, $urandom};
    Y_i = {$urandom, $urandom};
    n = 0;
    while (busy_o && !rdy_o && n < 80) begin
      n++;
      step();
    end
    check({tag, "_lat"}, 128'(n), 128'(lat));
    check({tag, "_rdy"}, {126'b0, busy_o, rdy_o}, 128'b01);
    check({tag, "_p"}, P_o, exp_p);
    repeat (hold) step();
    if (hold > 0) begin
      check({tag, "_hold_rdy"}, {126'b0, busy_o, rdy_o}, 128'b01);
      check({tag, "_hold_p"}, P_o, exp_p);
    end
    start_i = 1'b0;
    step();
    check({tag, "_release"}, {126'b0, busy_o, rdy_o}, 128'b00);
  endtask

  initial begin
    reset = 1'b0;
    start_i = 1'b0;
    X_i = '0;
    Y_i = '0;
    step();
    step();
    check("reset_flags", {126'b0, busy_o, rdy_o}, 128'b00);
    check("reset_p", P_o, 128'd0);
    reset = 1'b1;
    step();
    check("idle_flags", {126'b0, busy_o, rdy_o}, 128'b00);

    run_op("basic_3x5", 64'd3, 64'd5, 1);
    run_op("max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("zero_x", 64'd0, 64'h1234, 1);
    run_op("zero_y", 64'd7, 64'd0, 1);
    run_op("y_one", 64'hDEAD_BEEF_0123_4567, 64'd1, 0);

    // Abort after 10 RUN cycles; rdy_o must never assert.
    start_i = 1'b1;
    X_i = 64'd9;
    Y_i = 64'h8000_0000_0000_0000;
    step();
    repeat (10) step();
    check("abort_busy_before", {126'b0, busy_o, rdy_o}, 128'b10);
    start_i = 1'b0;
    step();
    check("abort_idle", {126'b0, busy_o, rdy_o}, 128'b00);
    repeat (3) step();
    check("abort_stays_idle", {126'b0, busy_o, rdy_o}, 128'b00);
    run_op("after_abort_2x2", 64'd2, 64'd2, 0);

    // Long hold after done, then reset in the middle of a run.
    run_op("hold5", 64'd1000, 64'd77, 5);
    start_i = 1'b1;
    X_i = 64'hFFFF_FFFF_FFFF_FFFF;
    Y_i = 64'h00FF_FFFF_FFFF_FFFF;
    step();
    repeat (20) step();
    reset = 1'b0;
    step();
    check("reset_mid_run_flags", {126'b0, busy_o, rdy_o}, 128'b00);
    check("reset_mid_run_p", P_o, 128'd0);
    reset = 1'b1;
    start_i = 1'b0;
    step();

    // Reset while in DONE with start still held.
    run_op("pre_reset_done", 64'd11, 64'd13, 0);
    start_i = 1'b1;
    X_i = 64'd6;
    Y_i = 64'd6;
    step();
    repeat (3) step();
    check("done_before_reset", {126'b0, busy_o, rdy_o}, 128'b01);
    reset = 1'b0;
    step();
    check("reset_mid_done", {126'b0, busy_o, rdy_o}, 128'b00);
    check("reset_mid_done_p", P_o, 128'd0);
    reset = 1'b1;
    start_i = 1'b0;
    step();

`ifdef MUL_SIGNED_EN
    run_op("signed_m3x5", -64'sd3, 64'd5, 1);
    run_op("signed_min", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1);
    run_op("signed_5xm1", 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 0);
`endif

    for (int i = 0; i < 24; i++) begin
      logic [63:0] rx;
      logic [63:0] ry;
      rx = {$urandom, $urandom} >> $urandom_range(0, 63);
      ry = {$urandom, $urandom} >> $urandom_range(0, 63);
      if ($urandom_range(0, 9) == 0) rx = 64'd0;
      if ($urandom_range(0, 9) == 0) ry = 64'd0;
      run_op($sformatf("rand%0d", i), rx, ry, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mul_seq_64.md
# mul_seq_64

Sequential 64×64 unsigned shift-add multiplier producing a 128-bit product. It is the multiply counterpart of the team's 64-bit sequential divider in the muldiv unit, and uses the same level-held `start_i` / `rdy_o` handshake so both blocks sit behind one arbiter. It retires one multiplier bit per cycle and terminates early at the highest set bit of `Y_i`; a zero operand finishes in a single cycle.

## Interface
- `W`, default 64: operand width. Product width is 2·W. The counter is clog2(W)+1 bits.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous, active-low; clock clk_i.
- `start_i`  in  1  request, level-held until `rdy_o` has been consumed.
- `X_i`  in  W  multiplicand, sampled only on the start edge.
- `Y_i`  in  W  multiplier, sampled only on the start edge.
- `busy_o`  out  1  high while in RUN.
- `rdy_o`  out  1  high while in DONE.
- `P_o`  out  2W  product register `acc`; valid while `rdy_o` is high.

## Operation
- Registers:
  - `mcand` (2W bits)
  - `mplier` (W bits)
  - `acc` (2W bits)
  - `cnt`
  - `state` ∈ {IDLE, RUN, DONE}
- Reset (`reset`=0 at an edge): state=IDLE and all registers cleared. Reset values: `rdy_o`=0, `busy_o`=0, `P_o`=0.
- IDLE, `start_i`=0: hold all registers.
- IDLE, `start_i`=1: the "start edge".
  - Load `mcand`={W'0, X_i}, `mplier`=Y_i, `acc`=0, `cnt`=msb(Y_i), where msb(Y_i) is the index of the highest set bit.
  - If X_i==0 or Y_i==0, go to DONE; `acc` remains 0.
  - Otherwise go to RUN.
- RUN, each edge:
  - If `mplier[0]`, then `acc` ← `acc`+`mcand` (2W-bit add; cannot overflow).
  - `mcand` ← `mcand`<<1, `mplier` ← `mplier`>>1.
  - If `cnt`==0, go to DONE; else `cnt` ← `cnt`−1.
- DONE: hold `acc`.
  - Stay in DONE while `start_i`=1.
  - On the first edge with `start_i`=0, go to IDLE. `acc` is retained, but `P_o` is not guaranteed valid in IDLE.
- Abort: `start_i`=0 at any RUN edge means that edge goes to IDLE and clears `acc`. No accumulation occurs on that edge.
- Operand changes after the start edge have no effect.
- A new operation requires `start_i` to be low for at least one edge. A continuously-high `start_i` never re-triggers.

## Timing
- Edge E0 is the start edge. With k = msb(Y_i):
  - RUN occupies edges E1..E(k+1).
  - `rdy_o` rises after E(k+1), i.e. latency k+1 cycles.
  - Worst case (Y bit 63 set): 64 cycles.
  - Best case (Y=1): 1 cycle.
- Zero operand: `rdy_o` rises after E0; `busy_o` never asserts.
- `rdy_o` and `busy_o` are decoded from `state` only, with no combinational path from inputs. They are never both high.
- `rdy_o` falls in the cycle after the first edge that samples `start_i`=0.
- Reset mid-RUN or mid-DONE takes priority over everything. Outputs are 0 after that edge.

## Configuration
- `MUL_SIGNED_EN` defined: X_i and Y_i are two's complement.
  - At the start edge, load the magnitudes |X_i| and |Y_i| (−2^(W−1) maps to 2^(W−1), which fits in W bits unsigned).
  - Register `neg` = X_i[W−1]^Y_i[W−1].
  - `P_o` = `neg` ? −`acc` : `acc` (combinational 2W-bit negate).
  - Latency follows msb(|Y_i|).
  - Zero detection is on the raw operands.
- `MUL_SIGNED_EN` undefined: unsigned only. No `neg` register and no negate logic.

## Test plan
- Basic unsigned multiply: X=3, Y=5, `start_i` held.
  - `busy_o` high for 3 cycles.
  - `rdy_o` high after E3 with `P_o`=128'd15.
- Maximum operands: X=Y=64'hFFFF_FFFF_FFFF_FFFF.
  - `rdy_o` after 64 cycles.
  - `P_o`=128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
- Zero operand: X=0, Y=64'h1234.
  - `rdy_o` high after E0, `busy_o` never high, `P_o`=0.
  - Repeat with X=7, Y=0: same result.
- Abort: X=9, Y=64'h8000_0000_0000_0000, drop `start_i` after 10 RUN cycles.
  - IDLE next edge, `busy_o`=0, `rdy_o` never asserts.
  - A new start with X=2, Y=2 then gives `P_o`=4 after 2 cycles.
- Handshake hold and reset:
  - `start_i` held for 5 cycles after done: `rdy_o` stays high and `P_o` is stable.
  - `start_i` dropped: `rdy_o`=0 one cycle later.
  - `reset`=0 asserted mid-RUN: `rdy_o`=0, `busy_o`=0, `P_o`=0 after that edge.
- With `MUL_SIGNED_EN`:
  - X=−3, Y=5: `P_o`=128'hFFFF…FFF1 (−15) after 3 cycles.
  - X=Y=−2^63: `P_o`=2^126 after 64 cycles.
